// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared constants and types for the NBBSOC UART transmitter.
//            Holds the MMIO address map of the peripheral bus, the TX state
//            encoding and a helper that packs the status word.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // MMIO address map of the peripherals on the NBBPU data bus
    localparam logic [15:0] ADDR_PWM       = 16'h8000;
    localparam logic [15:0] ADDR_ADC       = 16'h8010;
    localparam logic [15:0] ADDR_UART_DATA = 16'h8020;
    localparam logic [15:0] ADDR_UART_STAT = 16'h8021;

    // Transmitter state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Status word layout: {12'b0, overflow, full, empty, busy}
    function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic busy);
        return {12'b0, ovf, full, empty, busy};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : NBBPU data-bus slice seen by a memory-mapped peripheral.
// Ports    : write_enable, read_enable - bus strobes
//            address[15:0]             - bus address
//            write_data[15:0]          - bus write data
//            read_data[15:0]           - registered peripheral read data
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (
        output write_enable, read_enable, address, write_data,
        input  read_data
    );

    modport slave (
        input  write_enable, read_enable, address, write_data,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Synchronous byte FIFO with show-ahead output. Circular buffer
//            with wrapping pointers and a separate occupancy count.
// Ports    : clock, reset (async, active high)
//            push, din[7:0]  - write side; a push while full is accepted
//                              only when a pop happens on the same edge
//            pop, dout[7:0]  - read side; dout shows the head entry
//            empty, full     - occupancy flags from the registered count
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // The slot freed by a simultaneous pop makes a push-while-full legal
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    // Storage needs no reset: discarding contents is done via the pointers
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter. CPU pushes bytes into a
//            FIFO at BASE and polls status at BASE+1; the FSM serialises
//            FIFO contents LSB first with BAUD_DIV clocks per bit.
// Ports    : clock, reset (async, active high)
//            bus  - uart_tx_if.slave (strobes, address, data, read_data)
//            TX   - registered serial output, idles high
//            busy - high while a frame is on the line
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          BAUD_DIV   = 104,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASE       = ADDR_UART_DATA
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     TX,
    output logic     busy
);
    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [15:0]       STAT_ADDR = BASE + 16'd1;

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_next;
    logic [BAUD_W-1:0] w_baud_inc;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_overflow;
    logic [15:0]       r_read_data;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_stat_rd;
    logic              w_baud_tc;
    logic [7:0]        w_fifo_dout;
    logic              w_unused_wdata;

    // Only the low byte of the bus carries data
    assign w_unused_wdata = ^bus.write_data[15:8];

    assign w_push     = bus.write_enable && (bus.address == BASE);
    // A write strobe takes precedence, so a combined strobe is not a status read
    assign w_stat_rd  = bus.read_enable && !bus.write_enable && (bus.address == STAT_ADDR);
    assign w_baud_tc  = (r_baud_cnt == BAUD_LAST);
    assign w_baud_inc = w_baud_tc ? '0 : r_baud_cnt + 1'b1;

    assign busy          = (r_state != ST_IDLE);
    assign TX            = r_tx;
    assign bus.read_data = r_read_data;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.write_data[7:0]),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_baud_next = w_baud_inc;
                if (w_baud_tc) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_baud_next = w_baud_inc;
                if (w_baud_tc) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                w_baud_next = w_baud_inc;
                if (w_baud_tc) begin
                    // Chain straight into the next start bit when data waits
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_bit_next   = '0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // TX is registered from the next state so the line never glitches
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // MMIO: sticky overflow flag and registered read data
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_read_data <= '0;
        end else begin
            // Setting beats the clear-on-read
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_stat_rd) begin
                r_overflow <= 1'b0;
            end
            if (bus.read_enable) begin
                r_read_data <= w_stat_rd ? status_word(r_overflow, w_full, w_empty, busy) : '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. A frame-timing reference model
//            (byte queue plus remaining-clocks-of-frame counter) predicts TX,
//            busy and read_data after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int B     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * B;

    logic clock = 1'b0;
    logic reset;
    logic TX;
    logic busy;

    uart_tx_if bus ();

    uart_tx #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (DEPTH),
        .BASE       (ADDR_UART_DATA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .TX    (TX),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_q [$];
    int          m_rem = 0;      // clocks left in the frame on the line
    logic [7:0]  m_cur = 8'h00;  // byte being transmitted
    logic        m_ovf = 1'b0;
    logic [15:0] m_rd  = 16'h0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected line level from the position inside the current frame
    function automatic logic exp_tx();
        int idx;
        if (m_rem == 0) return 1'b1;
        idx = (FRAME - m_rem) / B;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    // Advance the model across one clock edge with the given bus inputs
    task automatic model_edge(input logic we, input logic re,
                              input logic [15:0] addr, input logic [15:0] wd);
        bit was_full  = (m_q.size() == DEPTH);
        bit was_empty = (m_q.size() == 0);
        bit was_busy  = (m_rem > 0);
        bit popped    = 1'b0;
        bit ovf_set   = 1'b0;
        if (re)
            m_rd = (!we && addr == ADDR_UART_STAT) ?
                   {12'b0, m_ovf, was_full, was_empty, was_busy} : 16'h0000;
        if (m_rem > 1) begin
            m_rem--;
        end else if (!was_empty) begin
            m_cur  = m_q.pop_front();
            m_rem  = FRAME;
            popped = 1'b1;
        end else begin
            m_rem = 0;
        end
        if (we && addr == ADDR_UART_DATA) begin
            if (!was_full || popped) m_q.push_back(wd[7:0]);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (re && !we && addr == ADDR_UART_STAT) m_ovf = 1'b0;
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later
    task automatic step(input logic we, input logic re,
                        input logic [15:0] addr, input logic [15:0] wd);
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.address      = addr;
        bus.write_data   = wd;
        @(posedge clock);
        model_edge(we, re, addr, wd);
        #1;
        check("tx",        {15'b0, TX},   {15'b0, exp_tx()});
        check("busy",      {15'b0, busy}, {15'b0, (m_rem > 0)});
        check("read_data", bus.read_data, m_rd);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, 1'b0, ADDR_UART_DATA, {8'($urandom), d});
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 1'b1, a, 16'h0000);
    endtask

    initial begin
        logic        we;
        logic        re;
        logic [15:0] addr;
        bit          found;

        reset            = 1'b1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.address      = 16'h0000;
        bus.write_data   = 16'h0000;
        repeat (3) @(negedge clock);
        check("reset_tx",   {15'b0, TX},   16'h0001);
        check("reset_busy", {15'b0, busy}, 16'h0000);
        check("reset_rd",   bus.read_data, 16'h0000);
        reset = 1'b0;
        idle(2);

        // Status and bus isolation
        rd(ADDR_UART_STAT);
        check("idle_status", bus.read_data, 16'h0002);
        rd(ADDR_PWM);
        check("pwm_read", bus.read_data, 16'h0000);
        rd(ADDR_UART_STAT);
        rd(ADDR_ADC);
        rd(ADDR_UART_STAT);
        rd(ADDR_UART_DATA);
        check("data_read", bus.read_data, 16'h0000);

        // Single byte
        wr(8'h55);
        idle(FRAME + 5);

        // FIFO fill, then overflow while the first frame is running
        for (int i = 1; i <= 5; i++) wr(8'(i));
        rd(ADDR_UART_STAT);
        check("fill_no_ovf", bus.read_data & 16'h0008, 16'h0000);
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        rd(ADDR_UART_STAT);
        check("ovf_status", bus.read_data, 16'h000D);
        rd(ADDR_UART_STAT);
        check("ovf_cleared", bus.read_data, 16'h0005);
        idle(6 * FRAME);

        // Simultaneous strobes at the status address
        step(1'b1, 1'b1, ADDR_UART_STAT, 16'h00AA);
        check("both_strobes_rd", bus.read_data, 16'h0000);
        idle(2);
        rd(ADDR_UART_STAT);
        check("both_strobes_nopush", bus.read_data, 16'h0002);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0:       addr = ADDR_UART_DATA;
                1:       addr = ADDR_UART_STAT;
                2:       addr = ADDR_PWM;
                3:       addr = ADDR_ADC;
                default: addr = 16'($urandom);
            endcase
            step(we, re, addr, 16'($urandom));
        end
        idle(6 * FRAME);

        // Reset during data bit 3, with a second byte waiting in the FIFO
        wr(8'($urandom));
        wr(8'($urandom));
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            if (m_rem > 0 && ((FRAME - m_rem) / B) == 4) found = 1'b1;
            else idle(1);
        end
        check("reached_bit3", {15'b0, found}, 16'h0001);
        #2 reset = 1'b1;
        #1;
        check("midframe_reset_tx",   {15'b0, TX},   16'h0001);
        check("midframe_reset_busy", {15'b0, busy}, 16'h0000);
        m_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
        m_rd  = 16'h0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(2 * FRAME);
        rd(ADDR_UART_STAT);
        check("post_reset_status", bus.read_data, 16'h0002);
        wr(8'hA3);
        idle(FRAME + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
